uart_tx_drain: RTL and testbench

Serial transmitter that drains the UART FIFO and drives the TX pin. It watches the FIFO empty flag and issues one-cycle read strobes, one word per frame. It accepts the registered read data one cycle later and shifts it out as an 8N1/8N2 UART frame at a fixed, parameterised bit period. It sits between the outbound FIFO's read port and the top-level `o_tx` pad.

---
 rtl/uart_tx_drain.sv | 128 ++++++++++++
 tb/tb_uart_tx_drain.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains the outbound FIFO one word per frame and
// serialises each word onto the TX pad as an 8N1 / 8N2 UART frame.
module uart_tx_drain #(
   parameter int CLKS_PER_BIT = 104,
   parameter int STOP_BITS    = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_empty,
   output logic       o_rd_en,
   input  logic [7:0] i_rd_data,
   input  logic       i_rd_valid,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   // index of the final stop bit (0 for one stop bit, 1 for two)
   localparam logic STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state;
   logic [CW-1:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        stop_idx;
   logic        bit_end;

   assign bit_end = (cnt == CNT_MAX);

   // status flags decode the state register and counters
   assign o_busy       = (state != IDLE);
   assign o_frame_done = (state == STOP) && bit_end &&
                         (stop_idx == STOP_LAST);

   // frame sequencer: fetch one word, then start, 8 data, stop bit(s)
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         stop_idx <= 1'b0;
         o_tx     <= 1'b1;
         o_rd_en  <= 1'b0;
      end else begin
         o_rd_en <= 1'b0;
         unique case (state)
            IDLE: begin
               o_tx <= 1'b1;
               if (i_enable && !i_empty) begin
                  o_rd_en <= 1'b1;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               state <= WAIT;
            end
            WAIT: begin
               // a read that raced an empty FIFO comes back invalid
               if (i_rd_valid) begin
                  shreg   <= i_rd_data;
                  cnt     <= '0;
                  bit_idx <= '0;
                  o_tx    <= 1'b0;
                  state   <= START;
               end else begin
                  state <= IDLE;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  o_tx    <= shreg[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt   <= '0;
                  shreg <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     stop_idx <= 1'b0;
                     o_tx     <= 1'b1;
                     state    <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     o_tx    <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (stop_idx == STOP_LAST) begin
                     state <= IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               o_tx  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: two instances (1 and 2 stop bits, 4 clocks/bit)
// fed by a FIFO model; a bench UART receiver checks every frame.
module tb_uart_tx_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = 2'b00;
  logic [1:0] empty;
  logic [1:0] rd_en;
  logic [1:0] rv = 2'b00;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [1:0] done;
  logic [7:0] rdat [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [2][64];
  int  wp [2] = '{0, 0};
  int  rp [2] = '{0, 0};
  bit  inv_req [2];
  bit  inv_done [2];

  logic [7:0] expq0 [$];
  logic [7:0] expq1 [$];
  int exp_rd [2] = '{0, 0};

  bit   act [2];
  int   c [2];
  int   gap [2];
  int   frames [2] = '{0, 0};
  int   rdcnt [2] = '{0, 0};
  int   last_rd [2] = '{0, 0};
  bit   prev_rd [2];
  bit   busy_chk [2];
  logic [7:0] sh [2];
  int   gapq [$];
  int   cyc = 0;

  assign empty[0] = (rp[0] == wp[0]);
  assign empty[1] = (rp[1] == wp[1]);

  uart_tx_drain #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en[0]),
    .i_empty(empty[0]), .o_rd_en(rd_en[0]),
    .i_rd_data(rdat[0]), .i_rd_valid(rv[0]),
    .o_tx(tx[0]), .o_busy(busy[0]), .o_frame_done(done[0])
  );

  uart_tx_drain #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en[1]),
    .i_empty(empty[1]), .o_rd_en(rd_en[1]),
    .i_rd_data(rdat[1]), .i_rd_valid(rv[1]),
    .o_tx(tx[1]), .o_busy(busy[1]), .o_frame_done(done[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s", tag);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k] && inv_req[k] && !inv_done[k]) begin
        rv[k]       <= 1'b0;
        inv_done[k] <= 1'b1;
      end else if (rd_en[k] && rp[k] != wp[k]) begin
        rdat[k] <= mem[k][rp[k] % 64];
        rv[k]   <= 1'b1;
        rp[k]   <= rp[k] + 1;
      end else begin
        rv[k] <= 1'b0;
      end
    end
  end

  function automatic logic [7:0] exp_get(input int k, input int i);
    return (k == 0) ? expq0[i] : expq1[i];
  endfunction

  function automatic int exp_sz(input int k);
    return (k == 0) ? expq0.size() : expq1.size();
  endfunction

  task automatic rx_step(input int k);
    int sb = (k == 0) ? 1 : 2;
    int last = 4 * (9 + sb) - 1;
    if (rst) begin
      if (act[k]) exp_rd[k]++;
      act[k] = 0;
      gap[k] = 0;
      busy_chk[k] = 0;
      prev_rd[k] = 0;
      return;
    end
    if (rd_en[k]) begin
      chk("rd_en_one_cycle", prev_rd[k] === 1'b0);
      rdcnt[k]++;
      last_rd[k] = cyc;
    end
    prev_rd[k] = rd_en[k];
    if (busy_chk[k]) begin
      chk("busy_fall", busy[k] === 1'b0);
      busy_chk[k] = 0;
    end
    if (!act[k]) begin
      chk("done_idle", done[k] === 1'b0);
      if (tx[k] == 1'b0) begin
        act[k] = 1;
        c[k] = 0;
        gapq.push_back(gap[k]);
        chk("start_latency", (cyc - last_rd[k]) === 2);
        chk("busy_start", busy[k] === 1'b1);
      end else begin
        gap[k]++;
      end
    end
    if (act[k]) begin
      if (c[k] >= 6 && c[k] <= 34 && (c[k] - 6) % 4 == 0)
        sh[k] = {tx[k], sh[k][7:1]};
      if ((c[k] == 38 || c[k] == 42) && c[k] <= last)
        chk("stop_high", tx[k] === 1'b1);
      chk("frame_done", done[k] === (c[k] == last));
      if (c[k] == last) begin
        if (exp_rd[k] < exp_sz(k)) begin
          chk("rx_byte", sh[k] === exp_get(k, exp_rd[k]));
        end else begin
          chk("rx_extra", exp_rd[k] === exp_sz(k));
        end
        exp_rd[k]++;
        frames[k]++;
        act[k] = 0;
        gap[k] = 0;
        busy_chk[k] = 1;
      end else begin
        c[k]++;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) rx_step(k);
  end

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wp[k] % 64] = b;
    wp[k]++;
    if (k == 0) expq0.push_back(b);
    else expq1.push_back(b);
  endtask

  task automatic wait_frames(input int k, input int n,
                             input string tag);
    for (int i = 0; i < 400; i++) begin
      if (frames[k] >= n) break;
      @(negedge clk);
    end
    chk(tag, frames[k] === n);
  endtask

  task automatic wait_rd(input int k, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (rd_en[k]) break;
      @(negedge clk);
    end
    chk(tag, rd_en[k] === 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit bad;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx === 2'b11);
    chk("rst_rd_en", rd_en === 2'b00);
    chk("rst_busy", busy === 2'b00);
    chk("rst_done", done === 2'b00);
    rst = 1'b0;
    en[0] = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({rd_en[0], tx[0], busy[0]} !== 3'b010) bad = 1;
    end
    chk("empty_idle", bad === 1'b0);

    r = rdcnt[0];
    push(0, 8'h55);
    wait_frames(0, 1, "single_frame");
    repeat (3) @(negedge clk);
    chk("single_rd_cnt", (rdcnt[0] - r) === 1);

    r = rdcnt[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'hA3);
    wait_frames(0, 4, "b2b_frames");
    repeat (3) @(negedge clk);
    chk("b2b_rd_cnt", (rdcnt[0] - r) === 3);
    chk("b2b_gap1", gapq[gapq.size() - 2] === 3);
    chk("b2b_gap2", gapq[gapq.size() - 1] === 3);

    r = rdcnt[0];
    inv_req[0] = 1'b1;
    push(0, 8'h3C);
    wait_frames(0, 5, "inv_frame");
    repeat (3) @(negedge clk);
    chk("inv_rd_cnt", (rdcnt[0] - r) === 2);
    chk("inv_seen", inv_done[0] === 1'b1);
    inv_req[0] = 1'b0;

    push(0, 8'h00);
    wait_rd(0, "rst_wait_rd");
    repeat (19) @(negedge clk);
    chk("pre_rst_tx", tx[0] === 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx[0] === 1'b1);
    chk("async_rst_busy", busy[0] === 1'b0);
    chk("async_rst_done", done[0] === 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rst_tx", tx[0] === 1'b1);
    chk("hold_rst_busy", busy[0] === 1'b0);
    @(negedge clk);
    rst = 1'b0;
    push(0, 8'hC3);
    wait_frames(0, 6, "post_rst_frame");

    r = rdcnt[1];
    push(1, 8'h96);
    push(1, 8'h4B);
    en[1] = 1'b1;
    wait_rd(1, "drop_wait_rd");
    repeat (27) @(negedge clk);
    en[1] = 1'b0;
    wait_frames(1, 1, "drop_frame");
    repeat (60) @(negedge clk);
    chk("drop_rd_cnt", (rdcnt[1] - r) === 1);
    chk("drop_busy", busy[1] === 1'b0);
    en[1] = 1'b1;
    wait_frames(1, 2, "reenable_frame");
    repeat (3) @(negedge clk);
    chk("reenable_rd_cnt", (rdcnt[1] - r) === 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
